// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the NN training sequencer.
package nn_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFwd,
    StBwd,
    StUpd,
    StDone,
    StErr
  } state_e;

  // Core operation codes
  localparam logic [1:0] OP_FWD = 2'b00;
  localparam logic [1:0] OP_BWD = 2'b01;
  localparam logic [1:0] OP_UPD = 2'b10;

  // Status nibble codes
  localparam logic [3:0] ST_IDLE = 4'h0;
  localparam logic [3:0] ST_FWD  = 4'h1;
  localparam logic [3:0] ST_BWD  = 4'h2;
  localparam logic [3:0] ST_UPD  = 4'h3;
  localparam logic [3:0] ST_DONE = 4'h5;
  localparam logic [3:0] ST_ERR  = 4'hE;

  // Checkbit constants
  localparam logic [15:0] CB_DONE   = 16'hAB51;
  localparam logic [7:0]  CB_ERR_HI = 8'hAB;

  function automatic logic [3:0] status_of(input state_e s);
    logic [3:0] code;
    code = ST_IDLE;
    case (s)
      StFwd:   code = ST_FWD;
      StBwd:   code = ST_BWD;
      StUpd:   code = ST_UPD;
      StDone:  code = ST_DONE;
      StErr:   code = ST_ERR;
      default: code = ST_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic is_phase(input state_e s);
    return (s == StFwd) || (s == StBwd) || (s == StUpd);
  endfunction

endpackage

// File: rtl/nn_seq_watchdog.sv
// Per-phase watchdog: counts cycles while enabled, flags the last allowed cycle.
module nn_seq_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clock,
  input  logic resetb,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] count_q;

  // Cycle counter; clear wins, holds at the last value instead of wrapping
  always_ff @(posedge clock) begin
    if (!resetb) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != Last)) begin
      count_q <= count_q + CntW'(1);
    end
  end

  assign timeout = enable && (count_q == Last);

endmodule

// File: rtl/nn_train_sequencer.sv
// Epoch/sample sequencer driving the NN core through FWD/BWD/UPD phases.
// Optional macro NN_SEQ_PERF_EN adds a saturating busy-cycle counter output.
module nn_train_sequencer
  import nn_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned EPOCH_W  = 8,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic                cfg_train,
  input  logic [SAMPLE_W-1:0] cfg_samples,
  input  logic [EPOCH_W-1:0]  cfg_epochs,
  output logic                core_req,
  output logic [1:0]          core_op,
  output logic [SAMPLE_W-1:0] core_sample,
  input  logic                core_ack,
  output logic                busy,
  output logic [3:0]          status,
  output logic [15:0]         checkbits,
`ifdef NN_SEQ_PERF_EN
  output logic [31:0]         perf_cycles,
`endif
  output logic                irq
);

  state_e              state_q, state_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [1:0]          op_q, op_d;
  logic                train_q, train_d;
  logic [SAMPLE_W-1:0] samples_q, samples_d;
  logic [EPOCH_W-1:0]  epochs_q, epochs_d;
  logic                busy_q;
  logic [3:0]          status_q, status_d;
  logic [15:0]         cb_q, cb_d;
  logic                irq_q, end_pulse;
  logic                wd_clear, wd_timeout, advance;

  nn_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .resetb  (resetb),
    .clear   (wd_clear),
    .enable  (busy_q),
    .timeout (wd_timeout)
  );

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d   = state_q;
    epoch_d   = epoch_q;
    sample_d  = sample_q;
    op_d      = op_q;
    train_d   = train_q;
    samples_d = samples_q;
    epochs_d  = epochs_q;
    end_pulse = 1'b0;
    wd_clear  = 1'b0;
    advance   = 1'b0;

    if (cfg_abort) begin
      state_d  = StIdle;
      epoch_d  = '0;
      sample_d = '0;
      op_d     = OP_FWD;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (cfg_start) begin
            train_d   = cfg_train;
            samples_d = cfg_samples;
            epochs_d  = cfg_epochs;
            epoch_d   = '0;
            sample_d  = '0;
            if ((cfg_samples == '0) || (cfg_epochs == '0)) begin
              state_d   = StDone;
              end_pulse = 1'b1;
            end else begin
              state_d  = StFwd;
              op_d     = OP_FWD;
              wd_clear = 1'b1;
            end
          end
        end
        StFwd: begin
          if (core_ack) begin
            if (train_q) begin
              state_d  = StBwd;
              op_d     = OP_BWD;
              wd_clear = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end else if (wd_timeout) begin
            state_d   = StErr;
            end_pulse = 1'b1;
          end
        end
        StBwd: begin
          if (core_ack) begin
            state_d  = StUpd;
            op_d     = OP_UPD;
            wd_clear = 1'b1;
          end else if (wd_timeout) begin
            state_d   = StErr;
            end_pulse = 1'b1;
          end
        end
        StUpd: begin
          if (core_ack) begin
            advance = 1'b1;
          end else if (wd_timeout) begin
            state_d   = StErr;
            end_pulse = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (advance) begin
        if (sample_q == samples_q - SAMPLE_W'(1)) begin
          if (epoch_q == epochs_q - EPOCH_W'(1)) begin
            // Indices left as-is so they never exceed the configured range
            state_d   = StDone;
            end_pulse = 1'b1;
          end else begin
            sample_d = '0;
            epoch_d  = epoch_q + EPOCH_W'(1);
            state_d  = StFwd;
            op_d     = OP_FWD;
            wd_clear = 1'b1;
          end
        end else begin
          sample_d = sample_q + SAMPLE_W'(1);
          state_d  = StFwd;
          op_d     = OP_FWD;
          wd_clear = 1'b1;
        end
      end
    end

    status_d = status_of(state_d);
    unique case (state_d)
      StFwd, StBwd, StUpd: cb_d = {8'(epoch_d), 8'(sample_d)};
      StDone:              cb_d = CB_DONE;
      StErr:               cb_d = {CB_ERR_HI, 6'b0, op_d};
      default:             cb_d = 16'h0000;
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q   <= StIdle;
      epoch_q   <= '0;
      sample_q  <= '0;
      op_q      <= OP_FWD;
      train_q   <= 1'b0;
      samples_q <= '0;
      epochs_q  <= '0;
      busy_q    <= 1'b0;
      status_q  <= ST_IDLE;
      cb_q      <= 16'h0000;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      epoch_q   <= epoch_d;
      sample_q  <= sample_d;
      op_q      <= op_d;
      train_q   <= train_d;
      samples_q <= samples_d;
      epochs_q  <= epochs_d;
      busy_q    <= is_phase(state_d);
      status_q  <= status_d;
      cb_q      <= cb_d;
      irq_q     <= end_pulse;
    end
  end

  assign core_req    = busy_q;
  assign busy        = busy_q;
  assign core_op     = op_q;
  assign core_sample = sample_q;
  assign status      = status_q;
  assign checkbits   = cb_q;
  assign irq         = irq_q;

`ifdef NN_SEQ_PERF_EN
  logic [31:0] perf_q;
  logic        start_go;

  assign start_go = cfg_start && !cfg_abort && !busy_q;

  // Busy-cycle counter, cleared on accepted start, saturating
  always_ff @(posedge clock) begin
    if (!resetb) begin
      perf_q <= '0;
    end else if (start_go) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
